// File: rtl/matriz_pkg.sv
// Shared constants and types for the 5x5 matrix coprocessor.
// Element k of a packed matrix lives at bits k*W +: W, k = row*N + col.
package matriz_pkg;

    localparam int N        = 5;
    localparam int W        = 8;
    localparam int MAT_BITS = N * N * W;
    localparam int IDX_W    = 5;

    localparam logic [IDX_W-1:0] LAST_IDX = 5'd24;

    typedef enum logic [1:0] {
        OP_PASS   = 2'b00,
        OP_TRANSP = 2'b01,
        OP_NEG    = 2'b10,
        OP_RSVD   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/transposicao_matriz.sv
// Combinational 5x5 transposition datapath.
// Output element (i,j) is input element (j,i).
module transposicao_matriz
    import matriz_pkg::*;
(
    input  logic [MAT_BITS-1:0] matrix_A,
    output logic [MAT_BITS-1:0] m_transposta_A
);

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            assign m_transposta_A[(i*N+j)*W +: W] =
                matrix_A[(j*N+i)*W +: W];
        end
    end

endmodule

// File: rtl/controle_transposicao.sv
// Sequencer: byte-serial load, one-cycle operation, handshaked drain
// of a 5x5 signed 8-bit matrix.
module controle_transposicao #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                err
);

    import matriz_pkg::*;

    if (N != 5 || W != 8) begin : g_bad_param
        $fatal(1, "controle_transposicao: only N=5, W=8 supported");
    end

    state_t state, state_d;
    op_t op_q;
    logic [IDX_W-1:0] idx, idx_d;
    logic [MAT_BITS-1:0] mat, res, res_d, mat_t;
    logic ld_en, ex_en, op_en;
    logic done_d, err_d;

    transposicao_matriz u_transp (
        .matrix_A       (mat),
        .m_transposta_A (mat_t)
    );

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        done_d    = 1'b0;
        err_d     = 1'b0;
        op_en     = 1'b0;
        ld_en     = 1'b0;
        ex_en     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (op_t'(op) == OP_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        op_en   = 1'b1;
                        idx_d   = '0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_en = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = EXEC;
                    end else begin
                        idx_d = idx + 5'd1;
                    end
                end
            end
            EXEC: begin
                ex_en   = 1'b1;
                state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (idx == LAST_IDX);
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Negation wraps: 8'h80 maps to itself.
    always_comb begin
        res_d = mat;
        unique case (op_q)
            OP_PASS:   res_d = mat;
            OP_TRANSP: res_d = mat_t;
            OP_NEG: begin
                for (int k = 0; k < N * N; k++) begin
                    res_d[k*W +: W] = -mat[k*W +: W];
                end
            end
            default:   res_d = mat;
        endcase
    end

    assign out_data = (state == DRAIN) ? res[idx*W +: W] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            op_q  <= OP_PASS;
            mat   <= '0;
            res   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            done  <= done_d;
            err   <= err_d;
            if (op_en) op_q <= op_t'(op);
            if (ld_en) mat[idx*W +: W] <= in_data;
            if (ex_en) res <= res_d;
        end
    end

endmodule

// File: tb/tb_controle_transposicao.sv
// Directed bench for controle_transposicao with a scoreboard queue.
module tb_controle_transposicao;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    int tdone = 0;

    logic [7:0] vin [25];
    logic [7:0] sb [$];

    controle_transposicao #(.N(5), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: push the 25 expected outputs for op o over vin.
    task automatic push_exp(input logic [1:0] o);
        logic [7:0] t;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                case (o)
                    2'b01:   t = vin[c*5 + r];
                    2'b10:   t = 8'd0 - vin[r*5 + c];
                    default: t = vin[r*5 + c];
                endcase
                sb.push_back(t);
            end
        end
    endtask

    task automatic do_start(input logic [1:0] o);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        @(negedge clk);
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic load(input int n, input bit stall, input bit poke);
        int k = 0;
        int g = 0;
        bit xfer;
        while (k < n && g < 5000) begin
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = vin[k];
            start    = poke && (k == 10);
            if (poke) op = 2'b10;
            xfer = in_valid && in_ready;
            @(negedge clk);
            if (xfer) k++;
            g++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("load_count", k, n);
    endtask

    task automatic drain(input bit stall);
        int n = 0;
        int g = 0;
        bit was_stall = 1'b0;
        logic [7:0] held = 8'h00;
        logic [7:0] e;
        while (n < 25 && g < 5000) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("in_ready_off", in_ready, 0);
            chk("done_early", done, 0);
            if (was_stall) chk("hold_data", out_data, held);
            was_stall = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                chk("data", out_data, e);
                chk("last", out_last, n == 24);
                n++;
            end
            @(negedge clk);
            g++;
        end
        out_ready = 1'b0;
        chk("drain_count", n, 25);
        chk("done_pulse", done, 1);
        chk("busy_idle", busy, 0);
        tdone = cyc;
        @(negedge clk);
        chk("done_once", done, 0);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Transpose of 1..25 with free-flowing handshakes
        for (int k = 0; k < 25; k++) vin[k] = 8'(k + 1);
        push_exp(2'b01);
        do_start(2'b01);
        load(25, 1'b0, 1'b0);
        drain(1'b0);
        chk("job_cycles", tdone - t0 + 1, 52);

        // Negate with wrap at -128
        for (int k = 0; k < 25; k++) vin[k] = 8'h00;
        vin[1] = 8'h01;
        vin[2] = 8'hFF;
        vin[3] = 8'h7F;
        vin[4] = 8'h80;
        push_exp(2'b10);
        do_start(2'b10);
        load(25, 1'b0, 1'b0);
        drain(1'b0);

        // Pass-through with random stalls on both sides
        for (int k = 0; k < 25; k++) vin[k] = 8'($urandom);
        push_exp(2'b00);
        do_start(2'b00);
        load(25, 1'b1, 1'b0);
        drain(1'b1);

        // Reserved op: err pulse, stays idle
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_in_ready", in_ready, 0);
        @(negedge clk);
        chk("err_once", err, 0);
        chk("err_busy2", busy, 0);

        // Start during LOAD is ignored
        for (int k = 0; k < 25; k++) vin[k] = 8'(k * 3 + 7);
        push_exp(2'b00);
        do_start(2'b00);
        load(25, 1'b0, 1'b1);
        drain(1'b0);

        // Reset mid-job aborts with no done
        for (int k = 0; k < 25; k++) vin[k] = 8'(k + 1);
        do_start(2'b01);
        load(10, 1'b0, 1'b0);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end

        // Fresh job after reset
        push_exp(2'b01);
        do_start(2'b01);
        load(25, 1'b0, 1'b0);
        drain(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/controle_transposicao.md
Name: controle_transposicao

Overview:
- Sequencer that wraps the combinational 5x5 transposition datapath.
- Loads a 5x5 signed 8-bit matrix element-serially from a byte stream and latches an operation code.
- Runs the operation (pass-through, transpose or negate) in one cycle, then streams the 25 result elements out with a valid/ready handshake.
- Sits between the host byte interface and the matrix datapath in the coprocessor.

Parameters:
- N, 5, matrix dimension. Only 5 is supported; any other value shall stop elaboration.
- W, 8, element width in bits. Only 8 is supported; any other value shall stop elaboration.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- op  in  2  operation: 00 pass, 01 transpose, 10 negate, 11 reserved.
- in_valid  in  1  input element valid.
- in_ready  out  1  block accepts an input element.
- in_data  in  8  signed input element, row-major order.
- out_valid  out  1  output element valid.
- out_ready  in  1  sink accepts an output element.
- out_data  out  8  signed result element, row-major order.
- out_last  out  1  marks element 24 of the output stream.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final output transfer.
- err  out  1  one-cycle pulse when start is seen with op=11.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, idx=0, matrix and result registers=0, op register=0. All outputs 0. Reset asserted mid-job aborts the job; no done pulse.
- Storage:
  - Matrix register mat[199:0], element k at bits k*8 +: 8, where k = row*5 + col.
  - Result register res has the same layout.
- FSM states: IDLE, LOAD, EXEC, DRAIN.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with op!=11: latch op, idx<=0, go to LOAD.
  - start=1 with op=11: err=1 for the next cycle, stay in IDLE.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: mat[idx] <= in_data, idx++.
  - The transfer at idx=24 goes to EXEC with idx<=0.
  - in_valid low stalls the load indefinitely.
- EXEC (one cycle):
  - in_ready=0.
  - res <= f(mat), where f is: identity for 00; the transposition datapath output for 01 (res element (i,j) = mat element (j,i)); per-element two's-complement negation for 10.
  - Negation wraps: -(-128) = -128 (8'h80 stays 8'h80). No saturation, no flag.
  - Go to DRAIN.
- DRAIN:
  - out_valid=1, out_data=res[idx], out_last=(idx==24).
  - On out_valid&&out_ready: idx++.
  - The transfer at idx=24 goes to IDLE with done=1 for exactly one cycle.
  - out_ready low holds out_data stable.
- Latency:
  - Last input accepted at edge k; EXEC is the state for the cycle after k; out_valid is high after edge k+1.
  - With in_valid and out_ready held high, a job is 1 (start) + 25 + 1 + 25 = 52 cycles, start to done.
- busy=1 in LOAD, EXEC and DRAIN.
- done and err are registered; they never overlap.

Decomposition:
- Shared package (matriz_pkg):
  - N=5, W=8.
  - MAT_BITS=200, LAST_IDX=24.
  - Op codes OP_PASS, OP_TRANSP, OP_NEG, OP_RSVD.
  - FSM state enum.
- Sub-module: instantiate the existing transposicao_matriz (matrix_A -> m_transposta_A) driven by mat. Negate and pass are inline.

Test Plan:
- Transpose: load elements 1..25 in order, op=01, out_ready=1 -> outputs 1,6,11,16,21,2,7,...,25. out_last is high only on 25. done pulses once; job takes 52 cycles.
- Negate with wrap: load 0,1,-1,127,-128, then 20 zeros, op=10 -> outputs 0,-1,1,-127,-128, then 20 zeros.
- Handshake stalls: op=00, toggle in_valid and out_ready pseudo-randomly -> output equals input sequence exactly. out_data stays stable while out_ready=0. in_ready is never high outside LOAD.
- Reserved op and ignored start:
  - start with op=11 -> err pulses one cycle, busy stays 0.
  - start during LOAD -> ignored, load continues unaffected.
- Reset mid-job: drop rst_n after 10 loaded elements -> all outputs 0 immediately (asynchronous), no done. A fresh job after release with 1..25, op=01 completes correctly.
